pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It watches ID-stage source registers, the EX-stage load destination, the IF redirect flag and halt/resume requests. It drives stop_IF, the ID/EX hold and flush controls, and a halted status. Decisions are combinational from the registered FSM state plus current inputs, so a hazard is covered in the cycle it appears.

---
 rtl/pipe_hazard_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Control outputs are combinational from the registered state plus the current inputs,
// so a hazard is covered in the same cycle it appears. Outputs are forced low in reset.
// Optional build macro PIPE_PERF_CNT_EN: when defined, stall_cycles/flush_cycles are live
// wrapping counters; when undefined, no counter flops exist and both ports read 0.
module pipe_hazard_ctrl #(
    parameter int unsigned LOAD_LAT     = 1,   // bubbles per load-use hazard (1..15)
    parameter int unsigned FLUSH_CYCLES = 1,   // flush cycles per redirect (1..15)
    parameter int unsigned CNT_WIDTH    = 32   // performance counter width
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           rs1_ID,
    input  logic [4:0]           rs2_ID,
    input  logic                 rs1_used,
    input  logic                 rs2_used,
    input  logic [4:0]           rd_EX,
    input  logic                 memRead_EX,
    input  logic                 risk_Ctrl,
    input  logic                 halt_req,
    input  logic                 resume,
    output logic                 stop_IF,
    output logic                 stop_ID,
    output logic                 flush_ID,
    output logic                 flush_EX,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_cycles
);

    typedef enum logic [1:0] {StRun, StStall, StFlush, StHalt} state_e;

    // cnt holds the number of extra cycles still owed after the current one
    localparam bit         LoadMulti  = (LOAD_LAT > 1);
    localparam bit         FlushMulti = (FLUSH_CYCLES > 1);
    localparam logic [3:0] LoadCnt    = LoadMulti  ? 4'(LOAD_LAT - 2)     : 4'd0;
    localparam logic [3:0] FlushCnt   = FlushMulti ? 4'(FLUSH_CYCLES - 2) : 4'd0;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic load_use;
    logic stop_if_c, stop_id_c, flush_id_c, flush_ex_c, halted_c;

    // Load in EX whose destination is read by the instruction in ID; x0 never hazards
    always_comb begin
        load_use = memRead_EX && (rd_EX != 5'd0) &&
                   ((rs1_used && (rs1_ID == rd_EX)) || (rs2_used && (rs2_ID == rd_EX)));
    end

    // Next-state and raw control decode from current state and inputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stop_if_c  = 1'b0;
        stop_id_c  = 1'b0;
        flush_id_c = 1'b0;
        flush_ex_c = 1'b0;
        halted_c   = 1'b0;
        unique case (state_q)
            StRun: begin
                if (risk_Ctrl) begin
                    // Redirect wins over load-use and halt; a coincident halt_req is dropped
                    flush_id_c = 1'b1;
                    flush_ex_c = 1'b1;
                    if (FlushMulti) begin
                        state_d = StFlush;
                        cnt_d   = FlushCnt;
                    end
                end else if (load_use) begin
                    stop_if_c  = 1'b1;
                    stop_id_c  = 1'b1;
                    flush_ex_c = 1'b1;
                    if (LoadMulti) begin
                        state_d = StStall;
                        cnt_d   = LoadCnt;
                    end
                end else if (halt_req) begin
                    stop_if_c  = 1'b1;
                    stop_id_c  = 1'b1;
                    flush_ex_c = 1'b1;
                    state_d    = StHalt;
                end
            end
            StStall: begin
                // The load ahead cannot redirect, so risk_Ctrl and halt_req are ignored here
                stop_if_c  = 1'b1;
                stop_id_c  = 1'b1;
                flush_ex_c = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StFlush: begin
                // The ID instruction is dead, so load_use is ignored; a new redirect restarts
                flush_id_c = 1'b1;
                flush_ex_c = 1'b1;
                if (risk_Ctrl) begin
                    if (FlushMulti) begin
                        cnt_d = FlushCnt;
                    end else begin
                        state_d = StRun;
                    end
                end else if (cnt_q == 4'd0) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StHalt: begin
                stop_if_c  = 1'b1;
                stop_id_c  = 1'b1;
                flush_ex_c = 1'b1;
                halted_c   = 1'b1;
                if (resume) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StRun;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Outputs drop to zero immediately while reset is asserted
    always_comb begin
        stop_IF  = rst_n & stop_if_c;
        stop_ID  = rst_n & stop_id_c;
        flush_ID = rst_n & flush_id_c;
        flush_EX = rst_n & flush_ex_c;
        halted   = rst_n & halted_c;
    end

    // State and down-counter registers, synchronous reset to RUN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StRun;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;

    // Wrapping event counters; reset cycles are never counted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stop_IF) begin
                stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
            end
            if (flush_ID) begin
                flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_cycles = flush_cnt_q;
`else
    assign stall_cycles = '0;
    assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances with different parameters share stimulus.
// A behavioural model (owed stall/flush cycles plus a halted flag) is checked every cycle,
// and a few literal expectations pin the model on the directed scenarios.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] rs1_ID, rs2_ID, rd_EX;
    logic       rs1_used, rs2_used, memRead_EX, risk_Ctrl, halt_req, resume;

    logic        a_stop_if, a_stop_id, a_flush_id, a_flush_ex, a_halted;
    logic [31:0] a_stall, a_flush;
    logic        b_stop_if, b_stop_id, b_flush_id, b_flush_ex, b_halted;
    logic [3:0]  b_stall, b_flush;

    pipe_hazard_ctrl #(.LOAD_LAT(1), .FLUSH_CYCLES(1), .CNT_WIDTH(32)) u_a (
        .clk(clk), .rst_n(rst_n), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .rd_EX(rd_EX), .memRead_EX(memRead_EX),
        .risk_Ctrl(risk_Ctrl), .halt_req(halt_req), .resume(resume),
        .stop_IF(a_stop_if), .stop_ID(a_stop_id), .flush_ID(a_flush_id), .flush_EX(a_flush_ex),
        .halted(a_halted), .stall_cycles(a_stall), .flush_cycles(a_flush)
    );

    pipe_hazard_ctrl #(.LOAD_LAT(3), .FLUSH_CYCLES(2), .CNT_WIDTH(4)) u_b (
        .clk(clk), .rst_n(rst_n), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .rd_EX(rd_EX), .memRead_EX(memRead_EX),
        .risk_Ctrl(risk_Ctrl), .halt_req(halt_req), .resume(resume),
        .stop_IF(b_stop_if), .stop_ID(b_stop_id), .flush_ID(b_flush_id), .flush_EX(b_flush_ex),
        .halted(b_halted), .stall_cycles(b_stall), .flush_cycles(b_flush)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Model configuration per instance
    int          ll   [2] = '{1, 3};
    int          fc   [2] = '{1, 2};
    logic [31:0] mask [2] = '{32'hFFFF_FFFF, 32'h0000_000F};

    // Model state: cycles still owed, halted flag, event counts
    int          stall_left [2] = '{0, 0};
    int          flush_left [2] = '{0, 0};
    bit          m_halted   [2] = '{1'b0, 1'b0};
    logic [31:0] m_stall    [2] = '{32'd0, 32'd0};
    logic [31:0] m_flush    [2] = '{32'd0, 32'd0};

    // Last sampled DUT outputs
    logic        o_stop_if [2], o_stop_id [2], o_flush_id [2], o_flush_ex [2], o_halted [2];
    logic [31:0] o_stall [2], o_flush [2];

    task automatic check1(input string name, input int idx, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] at %0t: got %b want %b", name, idx, $time, act, exp);
        end
    endtask

    task automatic checkw(input string name, input int idx, input logic [31:0] act,
                          input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] at %0t: got %0d want %0d", name, idx, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef PIPE_PERF_CNT_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    task automatic clear_inputs();
        rs1_ID = 5'd0; rs2_ID = 5'd0; rd_EX = 5'd0;
        rs1_used = 1'b0; rs2_used = 1'b0; memRead_EX = 1'b0;
        risk_Ctrl = 1'b0; halt_req = 1'b0; resume = 1'b0;
    endtask

    // One cycle: sample at negedge, compare against the model, advance the model
    task automatic step();
        bit lu, e_stop, e_fid, e_fex, e_halt;
        @(negedge clk);
        o_stop_if[0] = a_stop_if; o_stop_id[0] = a_stop_id; o_flush_id[0] = a_flush_id;
        o_flush_ex[0] = a_flush_ex; o_halted[0] = a_halted;
        o_stall[0] = a_stall; o_flush[0] = a_flush;
        o_stop_if[1] = b_stop_if; o_stop_id[1] = b_stop_id; o_flush_id[1] = b_flush_id;
        o_flush_ex[1] = b_flush_ex; o_halted[1] = b_halted;
        o_stall[1] = {28'd0, b_stall}; o_flush[1] = {28'd0, b_flush};
        lu = memRead_EX && (rd_EX != 5'd0) &&
             ((rs1_used && rs1_ID == rd_EX) || (rs2_used && rs2_ID == rd_EX));
        for (int i = 0; i < 2; i++) begin
            e_stop = 1'b0; e_fid = 1'b0; e_fex = 1'b0; e_halt = 1'b0;
            checkw("stall_cycles", i, o_stall[i], perf(m_stall[i]));
            checkw("flush_cycles", i, o_flush[i], perf(m_flush[i]));
            if (!rst_n) begin
                stall_left[i] = 0; flush_left[i] = 0; m_halted[i] = 1'b0;
            end else if (m_halted[i]) begin
                e_stop = 1'b1; e_fex = 1'b1; e_halt = 1'b1;
                if (resume) m_halted[i] = 1'b0;
            end else if (stall_left[i] > 0) begin
                e_stop = 1'b1; e_fex = 1'b1;
                stall_left[i]--;
            end else if (flush_left[i] > 0) begin
                e_fid = 1'b1; e_fex = 1'b1;
                if (risk_Ctrl) flush_left[i] = fc[i] - 1;
                else flush_left[i]--;
            end else if (risk_Ctrl) begin
                e_fid = 1'b1; e_fex = 1'b1;
                flush_left[i] = fc[i] - 1;
            end else if (lu) begin
                e_stop = 1'b1; e_fex = 1'b1;
                stall_left[i] = ll[i] - 1;
            end else if (halt_req) begin
                e_stop = 1'b1; e_fex = 1'b1;
                m_halted[i] = 1'b1;
            end
            check1("stop_IF", i, o_stop_if[i], e_stop);
            check1("stop_ID", i, o_stop_id[i], e_stop);
            check1("flush_ID", i, o_flush_id[i], e_fid);
            check1("flush_EX", i, o_flush_ex[i], e_fex);
            check1("halted", i, o_halted[i], e_halt);
            if (!rst_n) begin
                m_stall[i] = 32'd0; m_flush[i] = 32'd0;
            end else begin
                if (e_stop) m_stall[i] = (m_stall[i] + 32'd1) & mask[i];
                if (e_fid) m_flush[i] = (m_flush[i] + 32'd1) & mask[i];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_hazard(input logic [4:0] rd);
        memRead_EX = 1'b1; rd_EX = rd; rs1_ID = rd; rs1_used = 1'b1;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        halt_req = 1'b1;
        @(posedge clk);
        #1;

        // Reset held with halt_req asserted
        repeat (3) begin
            step();
            checkw("rst_stall_lit", 0, o_stall[0], 32'd0);
            check1("rst_stop_lit", 0, o_stop_if[0], 1'b0);
        end
        rst_n = 1'b1;
        halt_req = 1'b0;
        step();
        check1("post_rst_halted_lit", 0, o_halted[0], 1'b0);
        check1("post_rst_stop_lit", 1, o_stop_if[1], 1'b0);

        // Single load-use: 1 bubble on A, 3 on B
        set_hazard(5'd5);
        step();
        check1("lu_a_lit", 0, o_stop_if[0], 1'b1);
        check1("lu_b_lit", 1, o_stop_id[1], 1'b1);
        clear_inputs();
        step();
        check1("lu_a_end_lit", 0, o_stop_if[0], 1'b0);
        check1("lu_b_2_lit", 1, o_stop_if[1], 1'b1);
        step();
        check1("lu_b_3_lit", 1, o_stop_if[1], 1'b1);
        step();
        check1("lu_b_end_lit", 1, o_stop_if[1], 1'b0);

        // rd_EX = x0 never stalls
        set_hazard(5'd0);
        step();
        check1("x0_a_lit", 0, o_stop_if[0], 1'b0);
        check1("x0_b_lit", 1, o_stop_if[1], 1'b0);
        clear_inputs();

        // Redirect plus load-use: redirect wins, B flushes 2 cycles
        set_hazard(5'd7);
        risk_Ctrl = 1'b1;
        step();
        check1("rl_b_flush_lit", 1, o_flush_id[1], 1'b1);
        check1("rl_b_stop_lit", 1, o_stop_if[1], 1'b0);
        risk_Ctrl = 1'b0;
        step();
        check1("rl_b_flush2_lit", 1, o_flush_id[1], 1'b1);
        check1("rl_b_stop2_lit", 1, o_stop_if[1], 1'b0);
        clear_inputs();
        step();
        check1("rl_b_flush_end_lit", 1, o_flush_id[1], 1'b0);

        // Second redirect during FLUSH extends to a third cycle
        risk_Ctrl = 1'b1;
        step();
        step();
        risk_Ctrl = 1'b0;
        step();
        check1("ext_b_flush3_lit", 1, o_flush_id[1], 1'b1);
        step();
        check1("ext_b_flush_end_lit", 1, o_flush_id[1], 1'b0);

        // Halt for 10 cycles ignoring redirects, then resume
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        halt_req = 1'b1;
        step();
        check1("halt_req_stop_lit", 0, o_stop_if[0], 1'b1);
        halt_req = 1'b0;
        repeat (9) begin
            risk_Ctrl = 1'($urandom_range(0, 1));
            step();
            check1("halt_hold_lit", 0, o_halted[0], 1'b1);
        end
        risk_Ctrl = 1'b0;
        resume = 1'b1;
        step();
        check1("halt_resume_cycle_lit", 0, o_halted[0], 1'b1);
        resume = 1'b0;
        step();
        check1("halt_released_lit", 0, o_halted[0], 1'b0);
        checkw("halt_stall_count_lit", 0, o_stall[0], perf(32'd11));

        // 17 back-to-back stall cycles wrap the 4-bit counter to 1
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_hazard(5'd9);
        repeat (17) step();
        clear_inputs();
        step();
        checkw("wrap_b_lit", 1, o_stall[1], perf(32'd1));
        checkw("wrap_a_lit", 0, o_stall[0], perf(32'd17));

        // Randomized traffic with occasional mid-sequence resets
        repeat (3000) begin
            rst_n      = ($urandom_range(0, 49) != 0);
            rs1_ID     = 5'($urandom_range(0, 3));
            rs2_ID     = 5'($urandom_range(0, 3));
            rd_EX      = 5'($urandom_range(0, 3));
            rs1_used   = 1'($urandom_range(0, 1));
            rs2_used   = 1'($urandom_range(0, 1));
            memRead_EX = 1'($urandom_range(0, 1));
            risk_Ctrl  = ($urandom_range(0, 6) == 0);
            halt_req   = ($urandom_range(0, 19) == 0);
            resume     = ($urandom_range(0, 4) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
